decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/lib_pkg.sv | 65 ++++++
 rtl/decode_stage_if.sv | 24 ++
 rtl/decoder_core.sv | 84 ++++++++
 rtl/decode_stage.sv | 70 +++++++
 tb/tb_decode_stage.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lib_pkg.sv
// Shared types for the decode stage: instruction classes, RV opcode
// constants, the decoded bundle carried down the pipe, and the
// occupancy states of the two-entry skid buffer.
package lib_pkg;

  // imm and pc are carried at the widest supported XLEN. Narrower
  // instances sign-extend up to their own XLEN and leave every bit at
  // and above XLEN as zero.
  localparam int XLEN_MAX = 64;

  typedef enum logic [3:0] {
    OT_LUI     = 4'd0,
    OT_AUIPC   = 4'd1,
    OT_JAL     = 4'd2,
    OT_JALR    = 4'd3,
    OT_BRANCH  = 4'd4,
    OT_LOAD    = 4'd5,
    OT_STORE   = 4'd6,
    OT_OPIMM   = 4'd7,
    OT_OP      = 4'd8,
    OT_MISCMEM = 4'd9,
    OT_SYSTEM  = 4'd10,
    OT_MULDIV  = 4'd11,
    OT_OPIMM32 = 4'd12,
    OT_OP32    = 4'd13,
    OT_ILLEGAL = 4'd14
  } op_type_t;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    op_type_t              op_type;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [XLEN_MAX-1:0]   imm;
    logic [XLEN_MAX-1:0]   pc;
    logic                  illegal;
  } dec_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/decode_stage_if.sv
// Upstream/downstream handshake bundle of the decode stage. The master
// side is whoever feeds raw instructions and consumes decoded entries.
interface decode_stage_if import lib_pkg::*; #(
  parameter int XLEN = 32
) ();
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  dec_t            out_dec;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_dec
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_dec
  );
endinterface

// File: rtl/decoder_core.sv
// Purely combinational RV32/RV64 instruction decoder: field extraction,
// immediate formation and legality check.
module decoder_core import lib_pkg::*; #(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b0
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output dec_t            dec
);
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            f7_ok;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x;
  op_type_t        op;
  logic            bad;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign f7_ok  = (funct7 == F7_BASE) || (funct7 == F7_ALT) ||
                  (M_EXT && (funct7 == F7_MULDIV));

  // All formats fit in 32 bits once sign-extended from instr[31].
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_x = XLEN'($signed(imm32));

  // Classify the opcode, choose the immediate format and flag illegal encodings.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    op    = OT_ILLEGAL;
    imm32 = '0;
    bad   = 1'b0;
    case (opcode)
      OPC_LUI:     begin op = OT_LUI;     imm32 = imm_u; end
      OPC_AUIPC:   begin op = OT_AUIPC;   imm32 = imm_u; end
      OPC_JAL:     begin op = OT_JAL;     imm32 = imm_j; end
      OPC_JALR:    begin op = OT_JALR;    imm32 = imm_i; bad = (funct3 != 3'b000); end
      OPC_BRANCH:  begin op = OT_BRANCH;  imm32 = imm_b; end
      OPC_LOAD:    begin op = OT_LOAD;    imm32 = imm_i; end
      OPC_STORE:   begin op = OT_STORE;   imm32 = imm_s; end
      OPC_OPIMM:   begin op = OT_OPIMM;   imm32 = imm_i; end
      OPC_MISCMEM: begin op = OT_MISCMEM; imm32 = imm_i; end
      OPC_SYSTEM:  begin op = OT_SYSTEM;  imm32 = imm_i; end
      OPC_OP: begin
        op  = (M_EXT && (funct7 == F7_MULDIV)) ? OT_MULDIV : OT_OP;
        bad = !f7_ok;
      end
      OPC_OPIMM32: begin
        if (XLEN == 64) begin op = OT_OPIMM32; imm32 = imm_i; end
        else            bad = 1'b1;
      end
      OPC_OP32: begin
        if (XLEN == 64) begin op = OT_OP32; bad = !f7_ok; end
        else            bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
  end

  // Assemble the bundle; illegal entries keep their decoded fields.
  always_comb begin
    dec         = '0;
    dec.op_type = bad ? OT_ILLEGAL : op;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.funct3  = funct3;
    dec.funct7  = funct7;
    dec.imm     = XLEN_MAX'(imm_x);
    dec.pc      = XLEN_MAX'(pc);
    dec.illegal = bad;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decodes on the way in, then holds up to two
// decoded entries (output register plus one skid entry) so in_ready can
// come straight from registered occupancy with no path from out_ready.
module decode_stage import lib_pkg::*; #(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);
  occ_t occ_q, occ_d;
  dec_t out_q, out_d;
  dec_t skid_q, skid_d;
  dec_t dec_in;
  logic in_ready, out_valid, accept, retire;

  decoder_core #(.XLEN(XLEN), .M_EXT(M_EXT)) u_decoder_core (
    .instr (bus.in_instr),
    .pc    (bus.in_pc),
    .dec   (dec_in)
  );

  assign in_ready      = (occ_q != OCC_FULL);
  assign out_valid     = (occ_q != OCC_EMPTY);
  assign accept        = bus.in_valid && in_ready;
  assign retire        = out_valid && bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_dec   = out_q;

  // Next occupancy and entry movement; the skid entry always refills the output register.
  always_comb begin
    occ_d  = occ_q;
    out_d  = out_q;
    skid_d = skid_q;
    if (bus.flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: if (accept) begin out_d = dec_in; occ_d = OCC_ONE; end
        OCC_ONE: begin
          if (accept && retire) out_d = dec_in;
          else if (accept)      begin skid_d = dec_in; occ_d = OCC_FULL; end
          else if (retire)      occ_d = OCC_EMPTY;
        end
        OCC_FULL: if (retire) begin out_d = skid_q; occ_d = OCC_ONE; end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // Occupancy and entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: both entries are cleared on reset so nothing stale is ever
      // visible on out_dec; they are only two registers, not an array.
      occ_q  <= OCC_EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling
      // pre-edge values, so update order inside this block does not matter.
      occ_q  <= occ_d;
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a 32-bit instance without M and a 64-bit
// instance with M run the same traffic. Expected bundles are pushed on
// accept; a negedge monitor pops and compares on every retire.
module tb_decode_stage;
  import lib_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) if32 ();
  decode_stage_if #(.XLEN(64)) if64 ();

  decode_stage #(.XLEN(32), .M_EXT(1'b0)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
  decode_stage #(.XLEN(64), .M_EXT(1'b1)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64.slave));

  typedef struct {
    dec_t e32;
    dec_t e64;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode from the instruction-set rules, using signed arithmetic on the word.
  function automatic dec_t model(input logic [31:0] w, input logic [63:0] pc,
                                 input int xlen, input bit mext);
    dec_t d;
    int s;
    longint imm;
    bit ill;
    op_type_t t;
    logic [6:0] f7;
    bit f7_legal;
    s   = $signed(w);
    f7  = w[31:25];
    f7_legal = (f7 == 7'd0) || (f7 == 7'd32) || (mext && f7 == 7'd1);
    imm = 64'sd0;
    ill = 1'b0;
    t   = OT_ILLEGAL;
    case (w[6:0])
      7'h37: begin t = OT_LUI;   imm = longint'(s >>> 12) * 64'sd4096; end
      7'h17: begin t = OT_AUIPC; imm = longint'(s >>> 12) * 64'sd4096; end
      7'h6F: begin
        t = OT_JAL;
        imm = longint'(s >>> 31) * 64'sd1048576 + longint'(w[19:12]) * 64'sd4096 +
              longint'(w[20]) * 64'sd2048 + longint'(w[30:21]) * 64'sd2;
      end
      7'h67: begin t = OT_JALR; imm = longint'(s >>> 20); ill = (w[14:12] != 3'd0); end
      7'h63: begin
        t = OT_BRANCH;
        imm = longint'(s >>> 31) * 64'sd4096 + longint'(w[7]) * 64'sd2048 +
              longint'(w[30:25]) * 64'sd32 + longint'(w[11:8]) * 64'sd2;
      end
      7'h03: begin t = OT_LOAD;    imm = longint'(s >>> 20); end
      7'h23: begin t = OT_STORE;   imm = longint'(s >>> 25) * 64'sd32 + longint'(w[11:7]); end
      7'h13: begin t = OT_OPIMM;   imm = longint'(s >>> 20); end
      7'h33: begin t = (mext && f7 == 7'd1) ? OT_MULDIV : OT_OP; ill = !f7_legal; end
      7'h0F: begin t = OT_MISCMEM; imm = longint'(s >>> 20); end
      7'h73: begin t = OT_SYSTEM;  imm = longint'(s >>> 20); end
      7'h1B: if (xlen == 64) begin t = OT_OPIMM32; imm = longint'(s >>> 20); end else ill = 1'b1;
      7'h3B: if (xlen == 64) begin t = OT_OP32; ill = !f7_legal; end else ill = 1'b1;
      default: ill = 1'b1;
    endcase
    if (w[1:0] != 2'b11) ill = 1'b1;
    if (xlen == 32) imm = imm & 64'h0000_0000_FFFF_FFFF;
    d         = '0;
    d.op_type = ill ? OT_ILLEGAL : t;
    d.rs1     = w[19:15];
    d.rs2     = w[24:20];
    d.rd      = w[11:7];
    d.funct3  = w[14:12];
    d.funct7  = f7;
    d.imm     = imm;
    d.pc      = (xlen == 32) ? {32'b0, pc[31:0]} : pc;
    d.illegal = ill;
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] opcs [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                              7'h13, 7'h33, 7'h0F, 7'h73, 7'h1B, 7'h3B};
    logic [6:0] f7s [3] = '{7'h00, 7'h20, 7'h01};
    w = $urandom;
    if ($urandom_range(3) != 0) w[6:0] = opcs[$urandom_range(12)];
    if ($urandom_range(1) != 0) w[31:25] = f7s[$urandom_range(2)];
    if (w[6:0] == 7'h67 && $urandom_range(1) != 0) w[14:12] = 3'b000;
    return w;
  endfunction

  // One clock of stimulus; on accept the expected bundles go to the scoreboard.
  task automatic step(input bit v, input logic [31:0] w, input logic [63:0] pc,
                      input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    if32.in_valid = v; if32.in_instr = w; if32.in_pc = pc[31:0];
    if32.out_ready = ordy; if32.flush = fl;
    if64.in_valid = v; if64.in_instr = w; if64.in_pc = pc;
    if64.out_ready = ordy; if64.flush = fl;
    @(negedge clk);
    #1;
    if (fl) sb.delete();
    else if (v && if32.in_ready) sb.push_back('{model(w, pc, 32, 1'b0), model(w, pc, 64, 1'b1)});
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 32'h0, 64'h0, ordy, 1'b0);
  endtask

  // Monitor: handshake state against scoreboard depth, bundle compare on retire.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      check("in_ready32", if32.in_ready, sb.size() < 2);
      check("in_ready64", if64.in_ready, sb.size() < 2);
      check("out_valid32", if32.out_valid, sb.size() != 0);
      check("out_valid64", if64.out_valid, sb.size() != 0);
      if (if32.out_valid && if32.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got entry %0h expected none", if32.out_dec);
        end else begin
          e = sb.pop_front();
          check("dec32", if32.out_dec, e.e32);
          check("dec64", if64.out_dec, e.e64);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [63:0] pc;
    if32.in_valid = 0; if32.in_instr = '0; if32.in_pc = '0; if32.out_ready = 0; if32.flush = 0;
    if64.in_valid = 0; if64.in_instr = '0; if64.in_pc = '0; if64.out_ready = 0; if64.flush = 0;

    // Reset state
    #2;
    check("rst_out_valid32", if32.out_valid, 1'b0);
    check("rst_out_valid64", if64.out_valid, 1'b0);
    check("rst_in_ready32", if32.in_ready, 1'b1);
    check("rst_out_dec32", if32.out_dec, '0);
    check("rst_out_dec64", if64.out_dec, '0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // addi x1, x0, 5
    step(1'b1, 32'h0050_0093, 64'h0000_0000_0000_1000, 1'b1, 1'b0);
    idle(1'b1);
    check("addi_op", if32.out_dec.op_type, OT_OPIMM);
    check("addi_rd", if32.out_dec.rd, 5'd1);
    check("addi_rs1", if32.out_dec.rs1, 5'd0);
    check("addi_imm", if32.out_dec.imm, 64'd5);
    check("addi_illegal", if32.out_dec.illegal, 1'b0);

    // lui x1, 0x80000
    step(1'b1, 32'h8000_00B7, 64'hFFFF_0000_0000_2000, 1'b1, 1'b0);
    idle(1'b1);
    check("lui64_op", if64.out_dec.op_type, OT_LUI);
    check("lui64_rd", if64.out_dec.rd, 5'd1);
    check("lui64_imm", if64.out_dec.imm, 64'hFFFF_FFFF_8000_0000);
    check("lui32_imm", if32.out_dec.imm, 64'h0000_0000_8000_0000);

    // mul x0, x1, x2
    step(1'b1, 32'h0220_8033, 64'h3000, 1'b1, 1'b0);
    idle(1'b1);
    check("mul32_op", if32.out_dec.op_type, OT_ILLEGAL);
    check("mul32_illegal", if32.out_dec.illegal, 1'b1);
    check("mul64_op", if64.out_dec.op_type, OT_MULDIV);
    check("mul64_rd", if64.out_dec.rd, 5'd0);
    check("mul64_rs1", if64.out_dec.rs1, 5'd1);
    check("mul64_rs2", if64.out_dec.rs2, 5'd2);

    // All-zero word
    step(1'b1, 32'h0000_0000, 64'h4000, 1'b1, 1'b0);
    idle(1'b1);
    check("zero_illegal32", if32.out_dec.illegal, 1'b1);
    check("zero_illegal64", if64.out_dec.illegal, 1'b1);
    idle(1'b1);

    // Back-pressure: third offer refused, then in-order drain
    step(1'b1, 32'h0000_0013, 64'h5000, 1'b0, 1'b0);
    step(1'b1, 32'h0010_0113, 64'h5004, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0193, 64'h5008, 1'b0, 1'b0);
    check("full_in_ready", if32.in_ready, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush at full with a same-cycle offer
    step(1'b1, 32'h0030_0213, 64'h6000, 1'b0, 1'b0);
    step(1'b1, 32'h0040_0293, 64'h6004, 1'b0, 1'b0);
    step(1'b1, 32'h0050_0313, 64'h6008, 1'b0, 1'b1);
    idle(1'b1);
    check("flush_out_valid", if32.out_valid, 1'b0);
    check("flush_in_ready", if32.in_ready, 1'b1);
    idle(1'b1);

    // Reset mid-transfer with both entries held
    step(1'b1, 32'h0060_0393, 64'h7000, 1'b0, 1'b0);
    step(1'b1, 32'h0070_0413, 64'h7004, 1'b0, 1'b0);
    idle(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid32", if32.out_valid, 1'b0);
    check("midrst_out_valid64", if64.out_valid, 1'b0);
    check("midrst_out_dec64", if64.out_dec, '0);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(1'b1);
    idle(1'b1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      pc = {$urandom, $urandom};
      step($urandom_range(9) < 7, rand_instr(), pc, $urandom_range(9) < 6,
           $urandom_range(39) == 0);
    end

    // Drain whatever is left
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1);
    check("drain_empty", sb.size(), 0);
    idle(1'b1);
    check("drain_out_valid", if32.out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
